// File: rtl/ram_delay_line_if.sv
// ram_delay_line_if: control, data and status signals of the RAM-based delay line
interface ram_delay_line_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 4
);
  logic              enable;
  logic              flush;
  logic [ADDR_W:0]   delay;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              out_valid;
  logic              delay_clamped;
  modport master (output enable, flush, delay, data_in, input data_out, out_valid, delay_clamped);
  modport slave  (input enable, flush, delay, data_in, output data_out, out_valid, delay_clamped);
endinterface

// File: rtl/ram_delay_line.sv
// ram_delay_line: run-time programmable delay line on a circular RAM with fill-based valid
module ram_delay_line #(
  parameter int WIDTH     = 64,
  parameter int MAX_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic        clock,
  input  logic        rst,
  ram_delay_line_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MAX_DEPTH);
  localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MAX_DEPTH - 1);
  logic [WIDTH-1:0]  mem [MAX_DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d, rd;
  logic [ADDR_W:0]   fill_q, fill_d, fill_n, d, dm1, wp_x, rd_x;
  logic [WIDTH-1:0]  data_out_q, data_out_d, sel;
  logic              out_valid_q, out_valid_d, clamped_q, clamped_d, clamp, adv;

  // clamp the requested delay, locate the tap d-1 words behind wp, and compute next state
  always_comb begin
    adv         = bus.enable & ~bus.flush;
    clamp       = (bus.delay == '0) || (bus.delay > DEPTH);
    d           = (bus.delay == '0) ? ONE : (bus.delay > DEPTH) ? DEPTH : bus.delay;
    dm1         = d - ONE;
    wp_x        = {1'b0, wp_q};
    rd_x        = (wp_x >= dm1) ? wp_x - dm1 : wp_x + DEPTH - dm1;
    rd          = rd_x[ADDR_W-1:0];
    sel         = (d == ONE) ? bus.data_in : mem[rd];
    fill_n      = (fill_q == DEPTH) ? fill_q : fill_q + ONE;
    wp_d        = bus.flush ? '0 : adv ? ((wp_q == LAST) ? '0 : wp_q + 1'b1) : wp_q;
    fill_d      = bus.flush ? '0 : adv ? fill_n : fill_q;
    out_valid_d = bus.flush ? 1'b0 : adv ? (fill_n >= d) : out_valid_q;
    data_out_d  = bus.flush ? '0 : adv ? ((fill_n >= d) ? sel : '0) : data_out_q;
    clamped_d   = clamped_q | (adv & clamp);
  end

  // sample storage; contents are deliberately left unreset
  always_ff @(posedge clock) begin
    if (adv) mem[wp_q] <= bus.data_in;
  end

  // pointer, fill, registered output and sticky clamp flag
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      fill_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      clamped_q   <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      clamped_q   <= clamped_d;
    end
  end

  assign bus.data_out      = data_out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.delay_clamped = clamped_q;
endmodule

// File: tb/tb_ram_delay_line.sv
// tb_ram_delay_line: directed and model-checked scenarios for ram_delay_line
module tb_ram_delay_line;
  logic clock = 1'b0;
  logic rst   = 1'b1;
  int total = 0;
  int bad   = 0;

  ram_delay_line_if #(.WIDTH(64), .ADDR_W(4)) bus ();

  ram_delay_line #(.WIDTH(64), .MAX_DEPTH(16), .ADDR_W(4)) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick(input logic en, input logic [63:0] din);
    bus.enable  = en;
    bus.data_in = din;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== 66'd0) begin
      bad++; $display("FAIL reset_state: got v=%b c=%b d=%h want all 0", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    bus.delay = '0;
    tick(1'b1, 64'd5);
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== 66'd0) begin
      bad++; $display("FAIL reset_held: got v=%b c=%b d=%h want all 0", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    do_reset();
  endtask

  task automatic test_prime();
    logic [64:0] exp;
    do_reset();
    bus.delay = 5'd5;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 64'(k));
      exp = (k >= 5) ? {1'b1, 64'(k - 4)} : 65'd0;
      if ({bus.out_valid, bus.data_out} !== exp) begin
        bad++; $display("FAIL prime_edge%0d: got v=%b d=%0d want v=%b d=%0d", k, bus.out_valid, bus.data_out, exp[64], exp[63:0]);
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic [63:0] hist[$];
    logic [63:0] din, ed;
    logic en, ev;
    int mfill, errs;
    do_reset();
    bus.delay = 5'd5;
    mfill = 0; ed = '0; ev = 1'b0; errs = 0;
    for (int i = 0; i < 5000; i++) begin
      en  = 1'($urandom_range(0, 1));
      din = {$urandom, $urandom};
      tick(en, din);
      if (en) begin
        hist.push_front(din);
        if (hist.size() > 16) void'(hist.pop_back());
        mfill = (mfill < 16) ? mfill + 1 : 16;
        ev = (mfill >= 5);
        ed = ev ? hist[4] : 64'd0;
      end
      if ({bus.out_valid, bus.data_out} !== {ev, ed}) begin
        bad++; errs++;
        if (errs <= 5) $display("FAIL random_cyc%0d: got v=%b d=%h want v=%b d=%h", i, bus.out_valid, bus.data_out, ev, ed);
      end
      total++;
    end
  endtask

  task automatic test_bounds();
    logic [64:0] exp;
    do_reset();
    bus.delay = 5'd0;
    tick(1'b1, 64'd10);
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== {2'b11, 64'd10}) begin
      bad++; $display("FAIL delay0_first: got v=%b c=%b d=%0d want v=1 c=1 d=10", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    tick(1'b1, 64'd11);
    if ({bus.out_valid, bus.data_out} !== {1'b1, 64'd11}) begin
      bad++; $display("FAIL delay0_second: got v=%b d=%0d want v=1 d=11", bus.out_valid, bus.data_out);
    end
    total++;
    do_reset();
    bus.delay = 5'd16;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b1, 64'(100 + k));
      exp = (k >= 16) ? {1'b1, 64'(100 + k - 15)} : 65'd0;
      if ({bus.out_valid, bus.data_out} !== exp || bus.delay_clamped !== 1'b0) begin
        bad++; $display("FAIL delay16_edge%0d: got v=%b c=%b d=%0d want v=%b c=0 d=%0d", k, bus.out_valid, bus.delay_clamped, bus.data_out, exp[64], exp[63:0]);
      end
      total++;
    end
    do_reset();
    bus.delay = 5'd31;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, 64'(200 + k));
      exp = (k >= 16) ? {1'b1, 64'(200 + k - 15)} : 65'd0;
      if ({bus.out_valid, bus.data_out} !== exp || bus.delay_clamped !== 1'b1) begin
        bad++; $display("FAIL delay31_edge%0d: got v=%b c=%b d=%0d want v=%b c=1 d=%0d", k, bus.out_valid, bus.delay_clamped, bus.data_out, exp[64], exp[63:0]);
      end
      total++;
    end
  endtask

  task automatic test_delay_change();
    logic [64:0] exp;
    do_reset();
    bus.delay = 5'd4;
    for (int k = 1; k <= 6; k++) tick(1'b1, 64'(k));
    if ({bus.out_valid, bus.data_out} !== {1'b1, 64'd3}) begin
      bad++; $display("FAIL change_primed: got v=%b d=%0d want v=1 d=3", bus.out_valid, bus.data_out);
    end
    total++;
    bus.delay = 5'd8;
    tick(1'b0, 64'd77);
    if ({bus.out_valid, bus.data_out} !== {1'b1, 64'd3}) begin
      bad++; $display("FAIL change_idle_hold: got v=%b d=%0d want v=1 d=3", bus.out_valid, bus.data_out);
    end
    total++;
    for (int k = 7; k <= 10; k++) begin
      tick(1'b1, 64'(k));
      exp = (k >= 8) ? {1'b1, 64'(k - 7)} : 65'd0;
      if ({bus.out_valid, bus.data_out} !== exp) begin
        bad++; $display("FAIL change_edge%0d: got v=%b d=%0d want v=%b d=%0d", k, bus.out_valid, bus.data_out, exp[64], exp[63:0]);
      end
      total++;
    end
  endtask

  task automatic test_flush();
    logic [64:0] exp;
    do_reset();
    bus.delay = 5'd0;
    tick(1'b1, 64'd1);
    bus.delay = 5'd3;
    for (int k = 2; k <= 6; k++) tick(1'b1, 64'(k));
    if ({bus.out_valid, bus.data_out} !== {1'b1, 64'd4}) begin
      bad++; $display("FAIL flush_primed: got v=%b d=%0d want v=1 d=4", bus.out_valid, bus.data_out);
    end
    total++;
    bus.flush = 1'b1;
    tick(1'b1, 64'd99);
    bus.flush = 1'b0;
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== {2'b01, 64'd0}) begin
      bad++; $display("FAIL flush_clear: got v=%b c=%b d=%0d want v=0 c=1 d=0", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 64'(50 + k));
      exp = (k >= 2) ? {1'b1, 64'(48 + k)} : 65'd0;
      if ({bus.out_valid, bus.data_out} !== exp) begin
        bad++; $display("FAIL flush_reprime%0d: got v=%b d=%0d want v=%b d=%0d", k, bus.out_valid, bus.data_out, exp[64], exp[63:0]);
      end
      total++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.delay = 5'd0;
    tick(1'b1, 64'd7);
    bus.delay = 5'd2;
    for (int k = 1; k <= 4; k++) tick(1'b1, 64'(k));
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== {2'b11, 64'd3}) begin
      bad++; $display("FAIL async_pre: got v=%b c=%b d=%0d want v=1 c=1 d=3", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    rst = 1'b1;
    #1;
    if ({bus.out_valid, bus.delay_clamped, bus.data_out} !== 66'd0) begin
      bad++; $display("FAIL async_clear: got v=%b c=%b d=%0d want all 0", bus.out_valid, bus.delay_clamped, bus.data_out);
    end
    total++;
    rst = 1'b0;
    tick(1'b1, 64'd5);
    if ({bus.out_valid, bus.data_out} !== 65'd0) begin
      bad++; $display("FAIL async_reprime1: got v=%b d=%0d want v=0 d=0", bus.out_valid, bus.data_out);
    end
    total++;
    tick(1'b1, 64'd6);
    if ({bus.out_valid, bus.data_out} !== {1'b1, 64'd5}) begin
      bad++; $display("FAIL async_reprime2: got v=%b d=%0d want v=1 d=5", bus.out_valid, bus.data_out);
    end
    total++;
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.flush   = 1'b0;
    bus.delay   = '0;
    bus.data_in = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_prime();
    test_random();
    test_bounds();
    test_delay_change();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_delay_line.md
# ram_delay_line

Programmable-depth delay line for WIDTH-bit words, built on a circular RAM buffer rather than a register chain. Delay is selected at run time, from 1 to MAX_DEPTH enabled clocks. A fill counter drives an output-valid flag so downstream logic can ignore unprimed samples. A synchronous flush re-primes the line without a full reset. It is the general-purpose successor to the fixed-depth enabled delay register, for datapath alignment where the required latency is only known after configuration.

## Interface
- WIDTH, 64: data word width in bits.
- MAX_DEPTH, 16: largest supported delay and number of RAM words; any value ≥ 2, power of two not required.
- ADDR_W, 4: pointer width; must satisfy 2^ADDR_W ≥ MAX_DEPTH.

- clock  in  1  single clock for everything; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  advances the line by one sample on a clock edge.
- flush  in  1  synchronous clear of fill state; has priority over enable.
- delay  in  ADDR_W+1  requested delay, in enabled clocks.
- data_in  in  WIDTH  sample written on an enabled edge.
- data_out  out  WIDTH  delayed sample, registered.
- out_valid  out  1  high when data_out carries a sample that was actually written since the last reset or flush.
- delay_clamped  out  1  sticky flag: an out-of-range delay was used.

## Operation
- Storage:
  - mem[0..MAX_DEPTH-1], write pointer wp, fill counter fill (0..MAX_DEPTH, saturating).
  - RAM contents are not reset.
- Effective delay d, evaluated every edge from the current `delay`:
  - delay = 0 → d = 1.
  - delay > MAX_DEPTH → d = MAX_DEPTH.
  - Otherwise d = delay.
  - If the clamp applies on an edge where enable = 1 and flush = 0, delay_clamped is set and stays set until rst.
- Enabled edge (enable = 1, flush = 0):
  - mem[wp] ← data_in.
  - wp ← wp + 1, wrapping from MAX_DEPTH-1 to 0.
  - fill_n = min(fill + 1, MAX_DEPTH); fill ← fill_n.
  - Selected sample:
    - d = 1: data_in itself (write-through bypass).
    - d > 1: mem[(wp − (d−1)) mod MAX_DEPTH], read before this edge's write.
  - If fill_n ≥ d: data_out ← selected sample and out_valid ← 1.
  - Otherwise: data_out ← 0 and out_valid ← 0.
- Result: after the k-th enabled edge, data_out equals the data_in captured on enabled edge k−d+1. This is identical to a d-stage enabled shift register.
- Idle edge (enable = 0, flush = 0):
  - All state, data_out and out_valid hold.
  - Changes on `delay` have no effect until the next enabled edge.
- Flush edge (flush = 1, regardless of enable):
  - fill ← 0, wp ← 0, data_out ← 0, out_valid ← 0.
  - data_in is not written.
  - delay_clamped holds.
- Delay change while running:
  - No flush occurs.
  - The next enabled edge applies the new d immediately, so samples may be repeated or skipped.
  - out_valid is re-evaluated against the new d. Example: raising d above fill drops out_valid to 0 until fill catches up.

## Timing
- rst asserted (asynchronous): wp = 0, fill = 0, data_out = 0, out_valid = 0, delay_clamped = 0. All take effect immediately, not at the next edge.
- Latency: d enabled edges from sample capture to its appearance on data_out. Idle edges add wall-clock time but not stages.
- out_valid rises on the d-th enabled edge after reset or flush, and stays high while d ≤ fill.
- Simultaneous events:
  - flush with enable: flush wins.
  - rst dominates everything.
- Outputs change only on rising edges of clock, or on rst assertion.
- RAM may be an asynchronous-read LUTRAM/MLAB or registers; no extra pipeline stage is permitted.

## Test plan
- Reset and prime: WIDTH = 64, MAX_DEPTH = 16, delay = 5, enable = 1, data_in = 1, 2, 3, … → out_valid = 0 through edge 4. On edge 5, data_out = 1 and out_valid = 1. On edge 6, data_out = 2.
- Random enable vs reference: random data, enable and delay held at 5 for 5000 clocks → data_out and out_valid match a 5-stage enabled shift-register model with fill tracking on every edge.
- Bounds: delay = 0 → acts as d = 1 (data_out = previous edge's data_in) and delay_clamped = 1. delay = 16 → output appears 16 enabled edges later, across wp wrap. delay = 31 → acts as 16.
- Delay change: primed at d = 4, switch to 8 → out_valid = 0 for the next enabled edges until fill ≥ 8, then data_out = the sample captured 8 enabled edges earlier.
- Flush: primed at d = 3; flush = 1 together with enable = 1 → data_out = 0 and out_valid = 0. The next 3 enabled edges re-prime, and the third outputs the first post-flush sample.
- Async reset mid-stream: assert rst between clock edges with out_valid = 1 → data_out = 0, out_valid = 0 and delay_clamped = 0 without waiting for a clock edge. The line re-primes normally after release.
